// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one-at-a-time imem requests and fills IF/ID.
// Redirects (jump over branch) flush IF/ID and discard any response still in flight.
module pc_fetch_stage #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              stall_if,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic [DATA_W-1:0] branch_pc,
  input  logic [DATA_W-1:0] jump_pc,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] updated_pc
);

  localparam logic [2:0] StBoot = 3'd0;
  localparam logic [2:0] StReq  = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StHold = 3'd3;
  localparam logic [2:0] StKill = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] upc_q, upc_d;

  logic              redirect;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] pc_inc;
  logic              deliver;
  logic [DATA_W-1:0] deliver_word;

  assign redirect = jump | branch_taken;
  assign target   = jump ? jump_pc : branch_pc;
  assign pc_inc   = pc_q + DATA_W'(4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_d       = skid_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    upc_d        = upc_q;
    deliver      = 1'b0;
    deliver_word = '0;

    // imem_rvalid outside WAIT/KILL is a protocol error and is ignored.
    case (state_q)
      StBoot: state_d = StReq;
      StReq:  state_d = redirect ? StKill : StWait;
      StWait: begin
        if (redirect) begin
          state_d = imem_rvalid ? StReq : StKill;
        end else if (imem_rvalid) begin
          if (stall_if) begin
            skid_d  = imem_rdata;
            state_d = StHold;
          end else begin
            deliver      = 1'b1;
            deliver_word = imem_rdata;
            state_d      = StReq;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          skid_d  = '0;
          state_d = StReq;
        end else if (!stall_if) begin
          deliver      = 1'b1;
          deliver_word = skid_q;
          state_d      = StReq;
        end
      end
      StKill: begin
        if (imem_rvalid) state_d = StReq;
      end
      default: state_d = StBoot;
    endcase

    if (deliver) begin
      instr_d = deliver_word;
      upc_d   = pc_inc;
      pc_d    = pc_inc;
      valid_d = 1'b1;
    end

    // Redirect wins over stall and over any delivery in the same cycle.
    if (redirect) begin
      pc_d    = target;
      valid_d = 1'b0;
    end
  end

  assign req_d  = (state_d == StReq);
  assign addr_d = req_d ? pc_d : addr_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      skid_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      instr_q <= '0;
      upc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      upc_q   <= upc_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign updated_pc  = upc_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_pc_fetch_stage;

  logic        clk;
  logic        arst_n;
  logic        stall_if, branch_taken, jump;
  logic [31:0] branch_pc, jump_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr, updated_pc;

  int checks = 0;
  int errors = 0;

  pc_fetch_stage #(
    .DATA_W  (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .stall_if    (stall_if),
    .branch_taken(branch_taken),
    .jump        (jump),
    .branch_pc   (branch_pc),
    .jump_pc     (jump_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .updated_pc  (updated_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        s, j, b;
    logic [31:0] jpc, bpc;
    logic        rv;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr, upc;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic s, j, b, input logic [31:0] jpc, bpc,
                              input logic rv, input logic [31:0] rd,
                              input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] instr, upc);
    vec_t v;
    v.s = s; v.j = j; v.b = b; v.jpc = jpc; v.bpc = bpc; v.rv = rv; v.rd = rd;
    v.req = req; v.addr = addr; v.valid = valid; v.instr = instr; v.upc = upc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic valid, input logic [31:0] instr, upc);
    chk({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, req});
    chk({tag, ".imem_addr"}, imem_addr, addr);
    chk({tag, ".if_id_valid"}, {31'b0, if_id_valid}, {31'b0, valid});
    chk({tag, ".if_id_instr"}, if_id_instr, instr);
    chk({tag, ".updated_pc"}, updated_pc, upc);
  endtask

  task automatic drive(input logic s, j, b, input logic [31:0] jpc, bpc,
                       input logic rv, input logic [31:0] rd);
    stall_if = s; jump = j; branch_taken = b; jump_pc = jpc; branch_pc = bpc;
    imem_rvalid = rv; imem_rdata = rd;
  endtask

  // Inputs are driven at the falling edge and outputs are sampled at the next one.
  task automatic step(input logic s, j, b, input logic [31:0] jpc, bpc,
                      input logic rv, input logic [31:0] rd);
    drive(s, j, b, jpc, bpc, rv, rd);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: tracks the one possible in-flight fetch and whether it is doomed.
  logic [31:0] m_pc, m_skid, m_addr, m_instr, m_upc;
  logic        m_boot, m_issue, m_busy, m_doomed, m_skid_full, m_valid;

  task automatic model_reset();
    m_pc = 32'h0; m_skid = '0; m_addr = '0; m_instr = '0; m_upc = '0;
    m_boot = 1'b1; m_issue = 1'b0; m_busy = 1'b0; m_doomed = 1'b0;
    m_skid_full = 1'b0; m_valid = 1'b0;
  endtask

  task automatic model_step(input logic s, j, b, input logic [31:0] jpc, bpc,
                            input logic rv, input logic [31:0] rd);
    logic        redir, fetch_next, give;
    logic [31:0] word;
    redir = j | b;
    fetch_next = 1'b0;
    give = 1'b0;
    word = '0;
    if (m_boot) begin
      m_boot = 1'b0;
      fetch_next = 1'b1;
    end else if (m_issue) begin
      m_busy = 1'b1;
      m_doomed = redir;
    end else if (m_busy && rv) begin
      m_busy = 1'b0;
      if (m_doomed || redir) fetch_next = 1'b1;
      else if (s) begin m_skid_full = 1'b1; m_skid = rd; end
      else begin give = 1'b1; word = rd; fetch_next = 1'b1; end
    end else if (m_skid_full) begin
      if (redir) begin m_skid_full = 1'b0; fetch_next = 1'b1; end
      else if (!s) begin m_skid_full = 1'b0; give = 1'b1; word = m_skid; fetch_next = 1'b1; end
    end else if (m_busy && redir) begin
      m_doomed = 1'b1;
    end
    if (give) begin
      m_instr = word;
      m_upc = m_pc + 32'd4;
      m_pc = m_pc + 32'd4;
      m_valid = 1'b1;
    end
    if (redir) begin
      m_pc = j ? jpc : bpc;
      m_valid = 1'b0;
    end
    m_issue = fetch_next;
    if (fetch_next) m_addr = m_pc;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h1357_9BDF;
  endfunction

  initial begin
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_a;
    logic        rs, rj, rb, rv;
    logic [31:0] rjp, rbp, rd;

    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,                 1, 32'h0,   0, 32'h0,    32'h0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0,                 0, 32'h0,   0, 32'h0,    32'h0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1, 32'hA0,            1, 32'h4,   1, 32'hA0,   32'h4);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,                 0, 32'h4,   1, 32'hA0,   32'h4);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1, 32'hA4,            1, 32'h8,   1, 32'hA4,   32'h8);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0,                 0, 32'h8,   1, 32'hA4,   32'h8);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 32'hA8,            1, 32'hC,   1, 32'hA8,   32'hC);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0,                 0, 32'hC,   1, 32'hA8,   32'hC);
    tbl[8]  = mk(0, 1, 0, 32'h100, 0, 0, 0,           0, 32'hC,   0, 32'hA8,   32'hC);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,                 0, 32'hC,   0, 32'hA8,   32'hC);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 32'hBAD,           1, 32'h100, 0, 32'hA8,   32'hC);
    tbl[11] = mk(0, 1, 1, 32'h200, 32'h300, 0, 0,     0, 32'h100, 0, 32'hA8,   32'hC);
    tbl[12] = mk(0, 0, 0, 0, 0, 1, 32'hBAD2,          1, 32'h200, 0, 32'hA8,   32'hC);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0,                 0, 32'h200, 0, 32'hA8,   32'hC);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 32'hC200,          1, 32'h204, 1, 32'hC200, 32'h204);

    drive(0, 0, 0, 0, 0, 0, 0);
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("reset", 0, 32'h0, 0, 32'h0, 32'h0);
    arst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].s, tbl[i].j, tbl[i].b, tbl[i].jpc, tbl[i].bpc, tbl[i].rv, tbl[i].rd);
      chk_all($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid,
              tbl[i].instr, tbl[i].upc);
    end

    // Stall while the response returns: word parks in the skid until release.
    step(0, 0, 0, 0, 0, 0, 0);             chk_all("stall_wait", 0, 32'h204, 1, 32'hC200, 32'h204);
    step(1, 0, 0, 0, 0, 1, 32'hDEADBEEF);  chk_all("stall_hit",  0, 32'h204, 1, 32'hC200, 32'h204);
    step(1, 0, 0, 0, 0, 0, 0);             chk_all("stall_hold1", 0, 32'h204, 1, 32'hC200, 32'h204);
    step(1, 0, 0, 0, 0, 0, 0);             chk_all("stall_hold2", 0, 32'h204, 1, 32'hC200, 32'h204);
    step(0, 0, 0, 0, 0, 0, 0);             chk_all("stall_rel", 1, 32'h208, 1, 32'hDEADBEEF, 32'h208);

    // Redirect in HOLD: skid word must never appear.
    step(0, 0, 0, 0, 0, 0, 0);             chk_all("hold_wait", 0, 32'h208, 1, 32'hDEADBEEF, 32'h208);
    step(1, 0, 0, 0, 0, 1, 32'h5555);      chk_all("hold_in",   0, 32'h208, 1, 32'hDEADBEEF, 32'h208);
    step(1, 0, 1, 0, 32'h400, 0, 0);       chk_all("hold_redir", 1, 32'h400, 0, 32'hDEADBEEF, 32'h208);
    step(0, 0, 0, 0, 0, 0, 0);             chk_all("hold_wait2", 0, 32'h400, 0, 32'hDEADBEEF, 32'h208);
    step(0, 0, 0, 0, 0, 1, 32'h400A);      chk_all("hold_next", 1, 32'h404, 1, 32'h400A, 32'h404);

    // PC wrap at the top of the address space.
    step(0, 1, 0, 32'hFFFF_FFFC, 0, 0, 0); chk_all("wrap_jmp",  0, 32'h404, 0, 32'h400A, 32'h404);
    step(0, 0, 0, 0, 0, 1, 32'h1111);      chk_all("wrap_kill", 1, 32'hFFFF_FFFC, 0, 32'h400A, 32'h404);
    step(0, 0, 0, 0, 0, 0, 0);             chk_all("wrap_wait", 0, 32'hFFFF_FFFC, 0, 32'h400A, 32'h404);
    step(0, 0, 0, 0, 0, 1, 32'h7777);      chk_all("wrap_dlv",  1, 32'h0, 1, 32'h7777, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);             chk_all("wrap_w2",   0, 32'h0, 1, 32'h7777, 32'h0);

    // Asynchronous reset in the middle of WAIT, then stale responses after release.
    @(posedge clk);
    #2 arst_n = 1'b0;
    #1 chk_all("async_rst", 0, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    step(0, 0, 0, 0, 0, 1, 32'hBAD);       chk_all("stale_boot", 1, 32'h0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'hBAD);       chk_all("stale_req",  0, 32'h0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'hD0);        chk_all("restart",    1, 32'h4, 1, 32'hD0, 32'h4);

    // Randomized traffic with variable memory latency.
    drive(0, 0, 0, 0, 0, 0, 0);
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    model_reset();
    mem_pend = 1'b0;
    mem_cnt = 0;
    mem_a = '0;
    for (int c = 0; c < 2000; c++) begin
      chk_all("rnd", m_issue, m_addr, m_valid, m_instr, m_upc);
      rv = 1'b0;
      rd = $urandom;
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          rv = 1'b1;
          rd = mem_word(mem_a);
          mem_pend = 1'b0;
        end
      end
      if (imem_req) begin
        mem_pend = 1'b1;
        mem_cnt = int'($urandom_range(1, 3));
        mem_a = imem_addr;
      end
      rs = ($urandom_range(0, 99) < 30);
      rj = ($urandom_range(0, 99) < 6);
      rb = ($urandom_range(0, 99) < 8);
      rjp = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      rbp = $urandom & 32'hFFFF_FFFC;
      drive(rs, rj, rb, rjp, rbp, rv, rd);
      model_step(rs, rj, rb, rjp, rbp, rv, rd);
      @(posedge clk);
      @(negedge clk);
    end
    chk_all("rnd_end", m_issue, m_addr, m_valid, m_instr, m_upc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
